// File: rtl/sr_ff_bank.sv
// Bank of WIDTH synchronous SR flip-flops with selectable S=R=1 resolution,
// registered rise/fall edge pulses and a saturating conflict counter.
module sr_ff_bank #(
    parameter int unsigned            WIDTH         = 8,
    parameter int unsigned            CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0]       RESET_VAL     = '0,
    parameter int unsigned            CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    // Out-of-range modes fall back to hold.
    localparam logic [1:0] EFF_MODE = (CONFLICT_MODE > 3) ? 2'd0 : CONFLICT_MODE[1:0];

    logic [WIDTH-1:0] q_next;
    logic             conflict_next;

    always_comb begin
        q_next        = q;
        conflict_next = en & (|(s & r));
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                unique case ({s[i], r[i]})
                    2'b10:   q_next[i] = 1'b1;
                    2'b01:   q_next[i] = 1'b0;
                    2'b11: begin
                        unique case (EFF_MODE)
                            2'd1:    q_next[i] = 1'b1;
                            2'd2:    q_next[i] = 1'b0;
                            2'd3:    q_next[i] = ~q[i];
                            default: q_next[i] = q[i];
                        endcase
                    end
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q            <= RESET_VAL;
            rise         <= '0;
            fall         <= '0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            q        <= q_next;
            rise     <= q_next & ~q;
            fall     <= ~q_next & q;
            conflict <= conflict_next;
            // Clear beats a coincident increment; the counter never wraps.
            if (cnt_clr) begin
                conflict_cnt <= '0;
            end else if (conflict_next && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule
